// File: rtl/dmem_responder.sv
// Multi-cycle big-endian data memory responder with countdown wait states.
// Optional misalignment/reserved-size rejection is enabled by DMEM_ERR_EN.
module dmem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E,
    input  logic        RW,
    input  logic [1:0]  Size,
    input  logic [31:0] A,
    input  logic [31:0] DI,
    output logic [31:0] DO,
    output logic        READY,
    output logic        ERR
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic                rw_q;
    logic [1:0]          size_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         di_q;
    logic [7:0]          mem [DEPTH];

    logic [1:0]          eff_size;
    logic [ADDR_W-1:0]   a0, a1, a2, a3;
    logic                bad;
    logic [31:0]         rdata;
    logic                fire;
    logic                do_wr;
    logic                unused_addr_hi;

    assign unused_addr_hi = ^A[31:ADDR_W];

    // Resolve effective size/address and whether the access is rejected.
    always_comb begin
        bad      = 1'b0;
        eff_size = size_q;
        a0       = addr_q;
`ifdef DMEM_ERR_EN
        bad = (size_q == 2'b11)
            | ((size_q == 2'b01) & addr_q[0])
            | ((size_q == 2'b10) & (addr_q[1:0] != 2'b00));
`else
        if (size_q == 2'b11) eff_size = 2'b10;
        if (eff_size == 2'b01) a0[0] = 1'b0;
        if (eff_size == 2'b10) a0[1:0] = 2'b00;
`endif
        a1 = a0 + ADDR_W'(1);
        a2 = a0 + ADDR_W'(2);
        a3 = a0 + ADDR_W'(3);
    end

    // Big-endian read assembly, zero-extended.
    always_comb begin
        case (eff_size)
            2'b00:   rdata = {24'h0, mem[a0]};
            2'b01:   rdata = {16'h0, mem[a0], mem[a1]};
            default: rdata = {mem[a0], mem[a1], mem[a2], mem[a3]};
        endcase
    end

    assign fire  = (state == BUSY) && (cnt == '0);
    assign do_wr = fire && rw_q && !bad;

    // Byte array store; never reset, written only on a good write access.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            case (eff_size)
                2'b00: mem[a0] <= di_q[7:0];
                2'b01: begin
                    mem[a0] <= di_q[15:8];
                    mem[a1] <= di_q[7:0];
                end
                default: begin
                    mem[a0] <= di_q[31:24];
                    mem[a1] <= di_q[23:16];
                    mem[a2] <= di_q[15:8];
                    mem[a3] <= di_q[7:0];
                end
            endcase
        end
    end

`ifdef DMEM_ERR_EN
    logic err_q;
    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

    // Request latch, wait-state countdown and one-cycle response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            rw_q   <= 1'b0;
            size_q <= 2'b00;
            addr_q <= '0;
            di_q   <= '0;
            DO     <= '0;
            READY  <= 1'b0;
`ifdef DMEM_ERR_EN
            err_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (E) begin
                        rw_q   <= RW;
                        size_q <= Size;
                        addr_q <= A[ADDR_W-1:0];
                        di_q   <= DI;
                        cnt    <= CNT_W'(WAIT_CYCLES);
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        READY <= 1'b1;
                        state <= RESP;
                        if (bad) DO <= '0;
                        else if (!rw_q) DO <= rdata;
`ifdef DMEM_ERR_EN
                        err_q <= bad;
`endif
                    end
                end
                RESP: begin
                    READY <= 1'b0;
`ifdef DMEM_ERR_EN
                    err_q <= 1'b0;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-array reference model.
// Honours DMEM_ERR_EN the same way the design does.
module tb_dmem_responder;

    localparam int WAIT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        e = 1'b0, rw_i = 1'b0;
    logic [1:0]  size_i = 2'b00;
    logic [31:0] a_i = '0, di_i = '0;
    logic [31:0] dout;
    logic        ready, err;

    logic        e0 = 1'b0, rw0 = 1'b0;
    logic [1:0]  size0 = 2'b00;
    logic [31:0] a0 = '0, di0 = '0;
    logic [31:0] dout0;
    logic        ready0, err0;

    int total = 0;
    int bad = 0;

    logic [7:0]  m_mem [256];
    logic [31:0] m_do;
    logic [31:0] w0 [4];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(WAIT)) dut (
        .clk(clk), .reset(reset), .E(e), .RW(rw_i), .Size(size_i),
        .A(a_i), .DI(di_i), .DO(dout), .READY(ready), .ERR(err)
    );

    dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .E(e0), .RW(rw0), .Size(size0),
        .A(a0), .DI(di0), .DO(dout0), .READY(ready0), .ERR(err0)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_access(input logic rw, input logic [1:0] sz,
                                input logic [7:0] a, input logic [31:0] d,
                                output logic m_err);
        int n;
        int aa;
        logic [31:0] v;
        logic rej;
        int s;
        s = int'(sz);
        aa = int'(a);
`ifdef DMEM_ERR_EN
        rej = (s == 3) || (s == 1 && aa % 2 != 0) || (s == 2 && aa % 4 != 0);
`else
        rej = 1'b0;
        if (s == 3) s = 2;
        if (s == 1) aa = aa - aa % 2;
        if (s == 2) aa = aa - aa % 4;
`endif
        n = (s == 0) ? 1 : (s == 1) ? 2 : 4;
        m_err = rej;
        if (rej) begin
            m_do = 0;
        end else if (rw) begin
            for (int i = 0; i < n; i++)
                m_mem[(aa + i) % 256] = 8'(d >> (8 * (n - 1 - i)));
        end else begin
            v = 0;
            for (int i = 0; i < n; i++)
                v = (v << 8) | 32'(m_mem[(aa + i) % 256]);
            m_do = v;
        end
    endtask

    task automatic do_req(input string tag, input logic rw,
                          input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] data);
        int lat;
        bit got;
        logic m_err;
        @(negedge clk);
        e = 1'b1; rw_i = rw; size_i = sz; a_i = addr; di_i = data;
        @(posedge clk); #1;
        e = 1'b0; rw_i = 1'($urandom); size_i = 2'($urandom);
        a_i = $urandom; di_i = $urandom;
        model_access(rw, sz, addr[7:0], data, m_err);
        lat = 0;
        got = 0;
        while (!got && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (ready) got = 1;
        end
        chk({tag, ".lat"}, 32'(lat), 32'(WAIT + 1));
        chk({tag, ".do"}, dout, m_do);
        chk({tag, ".err"}, {31'h0, err}, {31'h0, m_err});
        @(posedge clk); #1;
        chk({tag, ".pulse"}, {31'h0, ready}, 32'h0);
    endtask

    initial begin
        m_do = 0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        #1;
        chk("rst.ready", {31'h0, ready}, 32'h0);
        chk("rst.err", {31'h0, err}, 32'h0);
        chk("rst.do", dout, 32'h0);

        for (int i = 0; i < 64; i++)
            do_req("init", 1'b1, 2'b10, 32'(4 * i), 32'h0);

        // abort a pending word write with reset
        @(negedge clk);
        e = 1'b1; rw_i = 1'b1; size_i = 2'b10;
        a_i = 32'h10; di_i = 32'hDEADBEEF;
        @(posedge clk); #1;
        e = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #2;
        chk("abort.ready", {31'h0, ready}, 32'h0);
        chk("abort.err", {31'h0, err}, 32'h0);
        chk("abort.do", dout, 32'h0);
        m_do = 0;
        @(negedge clk) reset = 1'b1;
        do_req("abort.rb", 1'b0, 2'b10, 32'h10, 32'h0);
        chk("abort.rb0", dout, 32'h0);

        do_req("ww", 1'b1, 2'b10, 32'h10, 32'hDEADBEEF);
        do_req("wr", 1'b0, 2'b10, 32'h10, 32'h0);
        chk("wr.const", dout, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++)
            do_req("br", 1'b0, 2'b00, 32'(16 + i), 32'h0);
        chk("br.last", dout, 32'h000000EF);

        do_req("sb", 1'b1, 2'b00, 32'h21, 32'h12345678);
        do_req("sh", 1'b1, 2'b01, 32'h22, 32'hAAAA5566);
        do_req("sw", 1'b0, 2'b10, 32'h20, 32'h0);
        chk("sw.const", dout, 32'h00785566);

        do_req("mh", 1'b0, 2'b01, 32'h31, 32'h0);
        do_req("mw", 1'b1, 2'b10, 32'h32, 32'hCAFEF00D);
        do_req("mrb", 1'b0, 2'b10, 32'h30, 32'h0);
`ifdef DMEM_ERR_EN
        chk("mrb.const", dout, 32'h0);
`else
        chk("mrb.const", dout, 32'hCAFEF00D);
`endif
        do_req("rsv", 1'b0, 2'b11, 32'h10, 32'h0);

        do_req("wrap.w", 1'b1, 2'b10, 32'hFFFFFF00, 32'h13579BDF);
        do_req("wrap.r", 1'b0, 2'b10, 32'h0, 32'h0);
        chk("wrap.const", dout, 32'h13579BDF);

        for (int i = 0; i < 150; i++)
            do_req("rnd", 1'($urandom), 2'($urandom), $urandom, $urandom);

        // back-to-back reads on the zero-wait instance
        for (int i = 0; i < 4; i++) begin
            w0[i] = $urandom;
            @(negedge clk);
            e0 = 1'b1; rw0 = 1'b1; size0 = 2'b10;
            a0 = 32'(4 * i); di0 = w0[i];
            @(negedge clk);
            e0 = 1'b0;
            repeat (3) @(negedge clk);
        end
        @(negedge clk);
        e0 = 1'b1; rw0 = 1'b0; size0 = 2'b10; a0 = 32'h0;
        begin
            int idx;
            idx = 0;
            for (int k = 0; k < 12; k++) begin
                @(posedge clk); #1;
                chk("b2b.ready", {31'h0, ready0},
                    {31'h0, 1'(k % 3 == 1)});
                if (ready0 && idx < 4) begin
                    chk("b2b.do", dout0, w0[idx]);
                    idx++;
                end
                if (k % 3 == 0) a0 = 32'(4 * (k / 3 + 1));
                if (k == 9) e0 = 1'b0;
            end
            chk("b2b.count", 32'(idx), 32'h4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
